// File: rtl/mem_load_unit.sv
// Load unit for the RV64I data-memory read path. Issues word reads to the
// 1-cycle-latency BRAM, tracks each in-flight load, and extracts and extends
// the selected byte, half, word or double, or reports a misaligned/illegal load.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   re, addr, func3     load request from the MEM stage
//   stall, flush        pipeline hold and cancel
//   mem_rdata           BRAM read data, valid the cycle after mem_en
//   mem_en, mem_addr    BRAM read enable and word address (combinational)
//   load_data           extended load result (0 for faulting loads)
//   load_valid          result pulse
//   misaligned, illegal fault qualifiers, valid with load_valid
module mem_load_unit #(
    parameter int ADDR_LSB = 3,
    parameter int MEM_AW   = 13,
    parameter bit OUT_REG  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [63:0]       addr,
    input  logic [2:0]        func3,
    input  logic              stall,
    input  logic              flush,
    input  logic [63:0]       mem_rdata,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic              illegal
);

    // ---------------- request decode ----------------
    logic accept;
    logic req_ill;
    logic req_mis_raw;
    logic req_mis;

    assign accept  = re & ~stall & ~flush;
    assign req_ill = &func3;

    always_comb begin
        req_mis_raw = 1'b0;
        unique case (func3[1:0])
            2'b00:   req_mis_raw = 1'b0;
            2'b01:   req_mis_raw = addr[0];
            2'b10:   req_mis_raw = |addr[1:0];
            default: req_mis_raw = |addr[2:0];
        endcase
    end

    // An illegal func3 is reported as illegal only, never as misaligned.
    assign req_mis  = req_mis_raw & ~req_ill;

    // Faulting loads never touch memory.
    assign mem_en   = accept & ~req_mis & ~req_ill;
    assign mem_addr = addr[ADDR_LSB+MEM_AW-1:ADDR_LSB];

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[63:ADDR_LSB+MEM_AW];

    // ---------------- stage-1 tag ----------------
    logic                t_valid_q, t_valid_d;
    logic [2:0]          t_f3_q, t_f3_d;
    logic [ADDR_LSB-1:0] t_off_q, t_off_d;
    logic                t_mis_q, t_mis_d;
    logic                t_ill_q, t_ill_d;

    always_comb begin
        t_valid_d = t_valid_q;
        t_f3_d    = t_f3_q;
        t_off_d   = t_off_q;
        t_mis_d   = t_mis_q;
        t_ill_d   = t_ill_q;
        if (flush) begin
            t_valid_d = 1'b0;
        end else if (!stall) begin
            t_valid_d = accept;
            if (accept) begin
                t_f3_d  = func3;
                t_off_d = addr[ADDR_LSB-1:0];
                t_mis_d = req_mis;
                t_ill_d = req_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid_q <= 1'b0;
            t_f3_q    <= '0;
            t_off_q   <= '0;
            t_mis_q   <= 1'b0;
            t_ill_q   <= 1'b0;
        end else begin
            t_valid_q <= t_valid_d;
            t_f3_q    <= t_f3_d;
            t_off_q   <= t_off_d;
            t_mis_q   <= t_mis_d;
            t_ill_q   <= t_ill_d;
        end
    end

    // ---------------- extraction ----------------
    logic [63:0] shifted;
    logic [63:0] ext;
    logic        sx;

    // Byte offset moves the addressed byte down to lane 0.
    assign shifted = mem_rdata >> {t_off_q, 3'b000};
    assign sx      = ~t_f3_q[2];

    always_comb begin
        ext = shifted;
        unique case (t_f3_q[1:0])
            2'b00:   ext = {{56{sx & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{48{sx & shifted[15]}}, shifted[15:0]};
            2'b10:   ext = {{32{sx & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    logic [63:0] res_data;
    logic        res_mis;
    logic        res_ill;

    assign res_mis  = t_valid_q & t_mis_q;
    assign res_ill  = t_valid_q & t_ill_q;
    assign res_data = (t_mis_q | t_ill_q) ? 64'd0 : ext;

    // ---------------- result stage ----------------
    if (OUT_REG) begin : g_out_reg
        logic        o_valid_q, o_valid_d;
        logic [63:0] o_data_q, o_data_d;
        logic        o_mis_q, o_mis_d;
        logic        o_ill_q, o_ill_d;

        always_comb begin
            o_valid_d = o_valid_q;
            o_data_d  = o_data_q;
            o_mis_d   = o_mis_q;
            o_ill_d   = o_ill_q;
            if (flush) begin
                o_valid_d = 1'b0;
                o_mis_d   = 1'b0;
                o_ill_d   = 1'b0;
            end else if (!stall) begin
                o_valid_d = t_valid_q;
                o_mis_d   = res_mis;
                o_ill_d   = res_ill;
                // Data is sticky until the next reported load.
                if (t_valid_q) begin
                    o_data_d = res_data;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o_valid_q <= 1'b0;
                o_data_q  <= '0;
                o_mis_q   <= 1'b0;
                o_ill_q   <= 1'b0;
            end else begin
                o_valid_q <= o_valid_d;
                o_data_q  <= o_data_d;
                o_mis_q   <= o_mis_d;
                o_ill_q   <= o_ill_d;
            end
        end

        assign load_valid = o_valid_q;
        assign load_data  = o_data_q;
        assign misaligned = o_mis_q;
        assign illegal    = o_ill_q;
    end else begin : g_out_comb
        logic vis;

        // A flush in the reporting cycle still cancels the load.
        assign vis        = t_valid_q & ~flush;
        assign load_valid = vis;
        assign load_data  = vis ? res_data : 64'd0;
        assign misaligned = vis & res_mis;
        assign illegal    = vis & res_ill;
    end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side counterpart of the data-memory store path in the RV64I pipelined CPU.
- Issues word-address reads to the 64-bit-wide, byte-laned synchronous data BRAM (1-cycle read latency).
- Tracks each in-flight load's func3 and byte offset, then extracts the byte, half, word or double from the returned 64-bit word and sign- or zero-extends it to 64 bits.
- Flags misaligned and illegal loads and supports pipeline stall and flush, so a result is produced only for loads that are not cancelled.

Parameters:
- ADDR_LSB, 3, byte-offset bits within a 64-bit memory word.
- MEM_AW, 13, memory word-address width; mem_addr = addr[ADDR_LSB+MEM_AW-1:ADDR_LSB].
- OUT_REG, 1, 1 = result registered (total latency 2); 0 = result combinational from mem_rdata (latency 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- re  in  1  load request from the MEM stage.
- addr  in  64  effective byte address.
- func3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- stall  in  1  pipeline hold; freezes all state.
- flush  in  1  cancels any in-flight load.
- mem_rdata  in  64  BRAM read data, valid the cycle after mem_en.
- mem_en  out  1  BRAM read enable (combinational).
- mem_addr  out  13  BRAM word address, addr[15:3] (combinational).
- load_data  out  64  extended load result.
- load_valid  out  1  one-cycle pulse marking a result (or fault).
- misaligned  out  1  fault qualifier, valid with load_valid.
- illegal  out  1  func3 = 111 qualifier, valid with load_valid.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0 and all internal valid/tag registers 0; no spurious pulse after release.
- Accept condition: a request is accepted when re=1, stall=0 and flush=0.
- mem_en: equals accept AND aligned AND legal. Faulting loads never read memory.
- Alignment: LH/LHU need addr[0]=0; LW/LWU need addr[1:0]=0; LD needs addr[2:0]=0; byte loads are always aligned.
- Stage-1 tag (captured on accept): {func3, addr[2:0], misaligned, illegal, valid}. A cycle with stall=0 and no accept clears valid.
- Extraction (stage 1, while the tag is valid): shift mem_rdata right by {offset,3'b000}, take the low 8/16/32/64 bits, then sign-extend (000/001/010) or zero-extend (100/101/110); LD passes all 64 bits through.
- Fault result: when misaligned or illegal is set, load_data = 0 and the matching flag(s) = 1. If both apply (func3=111), illegal takes priority and misaligned = 0.
- OUT_REG=1 timing:
  - Request accepted in cycle N; result registered at edge N+2.
  - load_valid high for exactly one cycle; load_data holds its value until the next result.
- OUT_REG=0 timing: load_valid, load_data and the flags are combinational in cycle N+1.
- Stall:
  - Tag and output registers hold; mem_en = 0, so the BRAM output holds.
  - load_valid stays asserted across the stall if it was high; no new pulse is generated.
  - The pulse completes on the first non-stall cycle.
- Flush:
  - Clears the stage-1 valid and suppresses the output pulse of any load not yet reported.
  - Flush beats stall when both are high.
- Back-to-back: one load per cycle is sustained with no bubbles.
- Reset mid-operation: in-flight loads are discarded immediately; no result pulse after release.
- Not supported here: any store-to-load forwarding.

Test Plan:
- Memory word 0x8877665544332211 at byte address 0x1000; LB 0x1003 -> load_data 0x0000000000000044, mem_addr 0x200. LB 0x1007 -> 0xFFFFFFFFFFFFFF88. LBU 0x1007 -> 0x0000000000000088.
- Same word: LH 0x1006 -> 0xFFFFFFFFFFFF8877. LHU 0x1006 -> 0x0000000000008877. LW 0x1004 -> 0xFFFFFFFF88776655. LWU 0x1004 -> 0x0000000088776655. LD 0x1000 -> 0x8877665544332211. Each with load_valid exactly at N+2 (OUT_REG=1).
- Faults: LH 0x1001, LW 0x1002, LD 0x1004 -> mem_en=0, load_valid with misaligned=1, load_data=0. func3=111 at 0x1000 -> illegal=1, misaligned=0.
- Four back-to-back LBU at 0x1000..0x1003 -> four consecutive pulses 0x11, 0x22, 0x33, 0x44. Then stall for 3 cycles mid-stream -> the pulse is held across the stall and the sequence resumes in order with no loss or duplication.
- Flush in cycle N+1 after an accepted LD -> no load_valid. Flush+stall together -> flush wins.
- Assert rst_n=0 asynchronously one cycle after an accept -> all outputs 0 immediately; after release no load_valid until a new request.
